ps2_key_sequencer: RTL and testbench

Single-clock PS/2 keyboard receive controller that sequences the keyboard datapath.
- Oversamples and filters psClk/psData, frames 11-bit packets and checks parity/stop.
- Decodes E0/F0 prefix sequences, suppresses typematic repeats via a held-key bitmap, and queues clean press/release events in a small FIFO with a valid/ready handshake.
- Sits between the PS/2 pins and game/control logic; replaces per-consumer decoding.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_rx_frame.sv | 144 ++++++++++++++
 rtl/ps2_key_sequencer.sv | 131 +++++++++++++
 tb/tb_ps2_key_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Frame FSM states, prefix byte codes and the queued key event.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_st_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       press;
  } ev_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: synchronizers, psClk glitch filter, 11-bit frame FSM.
// Ports: Clk, reset, psClk, psData in; byte_valid, byte_data, frame_err out.
import ps2_pkg::*;

module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       psClk,
  input  logic       psData,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic          r_clk_s1;
  logic          r_clk_s2;
  logic          r_dat_s1;
  logic          r_dat_s2;
  logic          r_clk_f;
  logic [FW-1:0] r_flt_cnt;

  logic          w_flip;
  logic          w_fall;

  frame_st_t     r_state;
  frame_st_t     w_next;
  logic [2:0]    r_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tmo;
  logic          r_byte_valid;
  logic          r_frame_err;

  logic          w_tmo;
  logic          w_good;
  logic          w_ok;
  logic          w_err;

  // Idle bus is high, so sync flops come out of reset at 1.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= psClk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= psData;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Flip on the FILTER_LEN-th consecutive differing sample.
  assign w_flip = (r_clk_s2 != r_clk_f) &&
                  (r_flt_cnt == FW'(FILTER_LEN - 1));
  assign w_fall = w_flip & r_clk_f;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_clk_f   <= 1'b1;
      r_flt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_f) begin
      r_flt_cnt <= '0;
    end else if (w_flip) begin
      r_clk_f   <= r_clk_s2;
      r_flt_cnt <= '0;
    end else begin
      r_flt_cnt <= r_flt_cnt + FW'(1);
    end
  end

  assign w_tmo = (r_state != IDLE) && !w_fall &&
                 (r_tmo == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_fall && !r_dat_s2) w_next = DATA;
      DATA:   if (w_fall && r_cnt == 3'd7) w_next = PARITY;
      PARITY: if (w_fall) w_next = STOP;
      STOP:   if (w_fall) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_tmo) w_next = IDLE;
  end

  always_comb begin
    w_good = r_dat_s2 & (^{r_shift, r_par});
    w_ok   = 1'b0;
    w_err  = w_tmo;
    unique case (r_state)
      IDLE:   w_err = w_err | (w_fall & r_dat_s2);
      STOP: begin
        w_ok  = w_fall & w_good;
        w_err = w_err | (w_fall & ~w_good);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_tmo        <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_ok;
      r_frame_err  <= w_err;
      if (r_state == IDLE || w_fall) r_tmo <= '0;
      else                           r_tmo <= r_tmo + TW'(1);
      if (w_fall) begin
        unique case (r_state)
          IDLE:   r_cnt <= '0;
          DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            r_cnt   <= r_cnt + 3'd1;
          end
          PARITY: r_par <= r_dat_s2;
          default: ;
        endcase
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_shift;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 key event sequencer: E0/F0 decode, held-key bitmap, event FIFO.
// Ports: PS/2 pins in; ev_* valid/ready queue, query lookup, error pulses out.
import ps2_pkg::*;

module ps2_key_sequencer #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       psClk,
  input  logic       psData,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_press,
  input  logic [6:0] query_code,
  output logic       query_held,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic         w_bv;
  logic [7:0]   w_code;

  logic         r_ext;
  logic         r_brk;
  logic [127:0] r_held;
  ev_t          r_mem [FIFO_DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         r_overflow;
  logic         r_query;

  logic         w_pfx_e;
  logic         w_pfx_b;
  logic         w_tracked;
  logic         w_repeat;
  logic         w_emit;
  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_push;
  logic [6:0]   w_idx;
  ev_t          w_ev;
  ev_t          w_head;
  logic [AW-1:0] w_rd_idx;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .Clk        (Clk),
    .reset      (reset),
    .psClk      (psClk),
    .psData     (psData),
    .byte_valid (w_bv),
    .byte_data  (w_code),
    .frame_err  (frame_err)
  );

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & ev_ready;

  always_comb begin
    w_idx     = w_code[6:0];
    w_pfx_e   = (w_code == PS2_EXT);
    w_pfx_b   = (w_code == PS2_BRK);
    w_tracked = ~r_ext & ~w_code[7];
    // Make of an already-held plain key is keyboard auto-repeat.
    w_repeat  = w_tracked & ~r_brk & r_held[w_idx];
    w_emit    = w_bv & ~w_pfx_e & ~w_pfx_b & ~w_repeat;
    w_push    = w_emit & (~w_full | w_pop);
    w_ev      = {w_code, r_ext, ~r_brk};
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_held <= '0;
    end else if (w_bv) begin
      if (w_pfx_e) begin
        r_ext <= 1'b1;
      end else if (w_pfx_b) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (w_tracked) r_held[w_idx] <= ~r_brk;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_query    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= w_ev;
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      r_overflow <= w_emit & w_full & ~w_pop;
      r_query    <= r_held[query_code];
    end
  end

  // Empty queue shows the most recently written entry.
  assign w_rd_idx = w_empty ? (r_wptr[AW-1:0] - AW'(1))
                            : r_rptr[AW-1:0];
  assign w_head   = r_mem[w_rd_idx];

  assign ev_valid   = ~w_empty;
  assign ev_code    = w_head.code;
  assign ev_ext     = w_head.ext;
  assign ev_press   = w_head.press;
  assign query_held = r_query;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: bit-banged PS/2 frames,
// events captured on handshake and compared to hand-computed values.
module tb_ps2_key_sequencer;

  localparam int TMO = 1024;
  localparam int HP  = 20;

  logic       Clk = 1'b0;
  logic       reset;
  logic       psClk;
  logic       psData;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_press;
  logic [6:0] query_code;
  logic       query_held;
  logic       frame_err;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int n_ferr = 0;
  int n_ovf  = 0;
  logic [9:0] evq[$];

  ps2_key_sequencer #(
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TMO),
    .FIFO_DEPTH  (4)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .psClk      (psClk),
    .psData     (psData),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_press   (ev_press),
    .query_code (query_code),
    .query_held (query_held),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!reset) begin
      if (ev_valid && ev_ready)
        evq.push_back({ev_code, ev_ext, ev_press});
      if (frame_err) n_ferr++;
      if (overflow)  n_ovf++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ev_at(input int i);
    if (i < evq.size()) return evq[i];
    return 10'h3FF;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    psData = b;
    cyc(HP);
    psClk = 1'b0;
    cyc(HP);
    psClk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic flip_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(1'b1);
    cyc(HP);
  endtask

  task automatic q_held(input logic [6:0] c,
                        output logic h);
    query_code = c;
    cyc(2);
    h = query_held;
  endtask

  logic h;
  int   f0;
  int   o0;
  int   n;

  initial begin
    reset = 1'b1;
    psClk = 1'b1;
    psData = 1'b1;
    ev_ready = 1'b0;
    query_code = '0;
    cyc(5);
    reset = 1'b0;
    cyc(3);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_held", query_held, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);

    // single make
    ev_ready = 1'b1;
    send_byte(8'h1C, 1'b0);
    chk("t1_cnt", evq.size(), 1);
    chk("t1_ev", ev_at(0), {8'h1C, 1'b0, 1'b1});
    q_held(7'h1C, h);
    chk("t1_held", h, 1);

    // typematic repeats then break
    evq.delete();
    repeat (3) send_byte(8'h1C, 1'b0);
    chk("t2_rep", evq.size(), 0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    chk("t2_cnt", evq.size(), 1);
    chk("t2_ev", ev_at(0), {8'h1C, 1'b0, 1'b0});
    q_held(7'h1C, h);
    chk("t2_held", h, 0);

    // extended make / break, untracked
    evq.delete();
    query_code = 7'h75;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk("t3_held_a", query_held, 0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk("t3_held_b", query_held, 0);
    chk("t3_cnt", evq.size(), 2);
    chk("t3_ev0", ev_at(0), {8'h75, 1'b1, 1'b1});
    chk("t3_ev1", ev_at(1), {8'h75, 1'b1, 1'b0});

    // parity error then good frame
    evq.delete();
    f0 = n_ferr;
    send_byte(8'h1C, 1'b1);
    chk("t4_ferr", n_ferr - f0, 1);
    chk("t4_noev", evq.size(), 0);
    send_byte(8'h1B, 1'b0);
    chk("t4_cnt", evq.size(), 1);
    chk("t4_ev", ev_at(0), {8'h1B, 1'b0, 1'b1});

    // fill FIFO with consumer stalled
    evq.delete();
    ev_ready = 1'b0;
    o0 = n_ovf;
    send_byte(8'h15, 1'b0);
    send_byte(8'h1D, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h2D, 1'b0);
    chk("t5_ovf0", n_ovf - o0, 0);
    send_byte(8'h2C, 1'b0);
    chk("t5_ovf1", n_ovf - o0, 1);
    chk("t5_valid", ev_valid, 1);
    chk("t5_head", {ev_code, ev_ext, ev_press}, {8'h15, 1'b0, 1'b1});
    q_held(7'h2C, h);
    chk("t5_held", h, 1);
    @(posedge Clk);
    #1 ev_ready = 1'b1;
    cyc(10);
    chk("t5_cnt", evq.size(), 4);
    chk("t5_ev0", ev_at(0), {8'h15, 1'b0, 1'b1});
    chk("t5_ev1", ev_at(1), {8'h1D, 1'b0, 1'b1});
    chk("t5_ev2", ev_at(2), {8'h24, 1'b0, 1'b1});
    chk("t5_ev3", ev_at(3), {8'h2D, 1'b0, 1'b1});
    chk("t5_empty", ev_valid, 0);

    // partial frame timeout
    evq.delete();
    f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    psData = 1'b1;
    n = 0;
    while (n_ferr == f0 && n < 3 * TMO) begin
      cyc(1);
      n++;
    end
    chk("t6_ferr", n_ferr - f0, 1);
    chk("t6_win", (n >= TMO - HP - 10) && (n <= TMO + 10), 1);
    chk("t6_noev", evq.size(), 0);
    send_byte(8'h1C, 1'b0);
    chk("t6_cnt", evq.size(), 1);
    chk("t6_ev", ev_at(0), {8'h1C, 1'b0, 1'b1});

    // reset mid-frame with queued events
    evq.delete();
    ev_ready = 1'b0;
    send_byte(8'h3B, 1'b0);
    send_byte(8'h42, 1'b0);
    chk("t7_q", ev_valid, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    f0 = n_ferr;
    reset = 1'b1;
    cyc(3);
    chk("t7_rvalid", ev_valid, 0);
    psData = 1'b1;
    psClk = 1'b1;
    reset = 1'b0;
    cyc(50);
    chk("t7_valid", ev_valid, 0);
    q_held(7'h42, h);
    chk("t7_held42", h, 0);
    q_held(7'h1C, h);
    chk("t7_held1c", h, 0);
    ev_ready = 1'b1;
    cyc(2 * TMO);
    chk("t7_noerr", n_ferr - f0, 0);
    chk("t7_noev", evq.size(), 0);
    send_byte(8'h1C, 1'b0);
    chk("t7_cnt", evq.size(), 1);
    chk("t7_ev", ev_at(0), {8'h1C, 1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
